// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_pkg
//  Purpose  : Shared constants and helpers for the miniRV fetch stage
//  Revision : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

    // Default PC after reset
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    // Bubble instruction: addi x0,x0,0
    localparam logic [31:0] C_NOP_INST = 32'h0000_0013;
    // Sequential fetch step in bytes
    localparam logic [31:0] C_PC_STEP  = 32'd4;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_pipe_reg_if_id.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_reg_if_id
//  Purpose  : IF/ID pipeline register; flush wins over keep, resets to bubble
//  Revision : 1.0  initial release
// ============================================================================
module pipe_reg_if_id
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = C_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        keep,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic [31:0] inst_out,
    output logic        valid_out
);

    logic [31:0] pc_q,   pc_d;
    logic [31:0] pc4_q,  pc4_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;

    // Next IF/ID contents: bubble on flush, hold on keep, otherwise capture IF
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush) begin
            pc_d    = 32'd0;
            pc4_d   = 32'd0;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!keep) begin
            pc_d    = pc_in;
            pc4_d   = pc_in + C_PC_STEP;
            inst_d  = inst_in;
            valid_d = 1'b1;
        end
    end

    // IF/ID state register, reset to the bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 32'd0;
            pc4_q   <= 32'd0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign pc4_out   = pc4_q;
    assign inst_out  = inst_q;
    assign valid_out = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : miniRV instruction fetch: PC register, next-PC mux, IF/ID
//             register and saturating stall/flush debug counters
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter logic [31:0] NOP_INST = C_NOP_INST,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             keep_PC,
    input  logic             keep_IF_ID,
    input  logic             flush_IF_ID,
    input  logic             npc_op,
    input  logic [31:0]      npc_target,
    output logic [31:0]      irom_addr,
    input  logic [31:0]      irom_inst,
    output logic [31:0]      pc_ID,
    output logic [31:0]      pc4_ID,
    output logic [31:0]      inst_ID,
    output logic             valid_ID,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Next PC: redirect beats stall, stall beats sequential increment
    always_comb begin
        pc_d = pc_q;
        if (npc_op) begin
            pc_d = align_word(npc_target);
        end else if (!keep_PC) begin
            pc_d = pc_q + C_PC_STEP;
        end
    end

    // Debug counters saturate at all-ones; a redirect overrides a PC hold so it is not a stall
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (keep_PC && !npc_op && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_IF_ID && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // PC and counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    pipe_reg_if_id #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .keep      (keep_IF_ID),
        .flush     (flush_IF_ID),
        .pc_in     (pc_q),
        .inst_in   (irom_inst),
        .pc_out    (pc_ID),
        .pc4_out   (pc4_ID),
        .inst_out  (inst_ID),
        .valid_out (valid_ID)
    );

    // ROM address comes straight from the PC flop
    assign irom_addr = pc_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage against a behavioural model
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam int C_CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        keep_PC, keep_IF_ID, flush_IF_ID, npc_op;
    logic [31:0] npc_target;
    logic [31:0] irom_addr, irom_inst;
    logic [31:0] pc_ID, pc4_ID, inst_ID;
    logic        valid_ID;
    logic [15:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the architectural state
    logic [31:0] m_pc, m_pc_id, m_pc4_id, m_inst_id;
    logic        m_valid;
    int          m_stall, m_flush;

    always #5 clk = ~clk;

    // Distinct word per address: odd multiply and xor are both bijective
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign irom_inst = rom(irom_addr);

    fetch_stage u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keep_PC     (keep_PC),
        .keep_IF_ID  (keep_IF_ID),
        .flush_IF_ID (flush_IF_ID),
        .npc_op      (npc_op),
        .npc_target  (npc_target),
        .irom_addr   (irom_addr),
        .irom_inst   (irom_inst),
        .pc_ID       (pc_ID),
        .pc4_ID      (pc4_ID),
        .inst_ID     (inst_ID),
        .valid_ID    (valid_ID),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_pc_id = 32'h0; m_pc4_id = 32'h0;
        m_inst_id = 32'h13; m_valid = 1'b0; m_stall = 0; m_flush = 0;
    endtask

    // One clock edge of the fetch stage, written from the operational rules
    task automatic model_edge();
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (npc_op)        m_pc = npc_target & 32'hFFFF_FFFC;
        else if (!keep_PC) m_pc = old_pc + 32'd4;
        if (flush_IF_ID) begin
            m_pc_id = 0; m_pc4_id = 0; m_inst_id = 32'h13; m_valid = 1'b0;
        end else if (!keep_IF_ID) begin
            m_pc_id = old_pc; m_pc4_id = old_pc + 32'd4; m_inst_id = rom(old_pc); m_valid = 1'b1;
        end
        if (keep_PC && !npc_op && m_stall < C_CNT_MAX) m_stall++;
        if (flush_IF_ID && m_flush < C_CNT_MAX) m_flush++;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".addr"},  irom_addr, m_pc);
        chk({tag, ".pcid"},  pc_ID, m_pc_id);
        chk({tag, ".pc4id"}, pc4_ID, m_pc4_id);
        chk({tag, ".inst"},  inst_ID, m_inst_id);
        chk({tag, ".valid"}, {31'd0, valid_ID}, {31'd0, m_valid});
        chk({tag, ".stall"}, {16'd0, stall_cnt}, m_stall);
        chk({tag, ".flush"}, {16'd0, flush_cnt}, m_flush);
    endtask

    // Drive inputs mid-cycle, take one edge, then compare on the falling edge
    task automatic cyc(input logic kpc, input logic kif, input logic fl,
                       input logic nop, input logic [31:0] tgt, input string tag);
        keep_PC = kpc; keep_IF_ID = kif; flush_IF_ID = fl; npc_op = nop; npc_target = tgt;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        keep_PC = 0; keep_IF_ID = 0; flush_IF_ID = 0; npc_op = 0; npc_target = 0;
        model_reset();
        @(negedge clk);
        chk_all("reset");
        chk("reset_inst_nop", inst_ID, 32'h0000_0013);
        rst_n = 1'b1;

        // Reset then run
        cyc(0, 0, 0, 0, 0, "run0");
        chk("run0_addr", irom_addr, 32'h4);
        chk("run0_inst", inst_ID, rom(32'h0));
        cyc(0, 0, 0, 0, 0, "run1");
        chk("run1_addr", irom_addr, 32'h8);
        cyc(0, 0, 0, 0, 0, "run2");
        cyc(0, 0, 0, 0, 0, "run3");
        chk("run3_addr", irom_addr, 32'h10);

        // Load-use stall
        cyc(1, 1, 0, 0, 0, "stall");
        chk("stall_addr", irom_addr, 32'h10);
        chk("stall_pcid", pc_ID, 32'h0C);
        chk("stall_cnt1", {16'd0, stall_cnt}, 32'd1);
        cyc(0, 0, 0, 0, 0, "stall_rel");
        chk("stall_rel_pcid", pc_ID, 32'h10);

        // Taken branch with flush
        cyc(0, 0, 1, 1, 32'h40, "br");
        chk("br_addr", irom_addr, 32'h40);
        chk("br_valid", {31'd0, valid_ID}, 32'd0);
        chk("br_flushcnt", {16'd0, flush_cnt}, 32'd1);
        cyc(0, 0, 0, 0, 0, "br1");
        chk("br1_pcid", pc_ID, 32'h40);
        chk("br1_valid", {31'd0, valid_ID}, 32'd1);

        // Simultaneous events
        cyc(1, 0, 0, 1, 32'h80, "redir_stall");
        chk("redir_stall_addr", irom_addr, 32'h80);
        chk("redir_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        cyc(0, 1, 1, 0, 0, "flush_keep");
        chk("flush_keep_valid", {31'd0, valid_ID}, 32'd0);

        // Misaligned target and wrap-around
        cyc(0, 0, 0, 1, 32'h43, "misal");
        chk("misal_addr", irom_addr, 32'h40);
        cyc(0, 0, 0, 1, 32'hFFFF_FFFE, "top");
        cyc(0, 0, 0, 0, 0, "wrap");
        chk("wrap_addr", irom_addr, 32'h0);
        chk("wrap_pc4", pc4_ID, 32'h0);

        // Randomised mixed traffic
        for (int i = 0; i < 400; i++) begin
            logic kpc, kif, fl, nop;
            kpc = ($urandom_range(0, 3) == 0);
            kif = ($urandom_range(0, 4) == 0) ? ~kpc : kpc;
            nop = ($urandom_range(0, 7) == 0);
            fl  = nop ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            cyc(kpc, kif, fl, nop, $urandom, "rand");
        end

        // Stall counter saturation
        keep_PC = 1; keep_IF_ID = 1; flush_IF_ID = 0; npc_op = 0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        chk_all("sat");
        chk("sat_stall", {16'd0, stall_cnt}, 32'h0000_FFFF);

        // Asynchronous reset between edges while stalled
        cyc(1, 1, 0, 0, 0, "pre_arst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("arst");
        chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, "post_arst");
        chk("post_arst_inst", inst_ID, rom(32'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
